// File: rtl/fpc_op_sched_if.sv
// fpc_op_sched_if: request, Fpc issue/result and response channels of the op scheduler
interface fpc_op_sched_if #(parameter int TAG_W = 4);
  logic req_valid;
  logic req_ready;
  logic req_mode;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic fpc_in_valid;
  logic fpc_mode;
  logic [15:0] fpc_in_a;
  logic [15:0] fpc_in_b;
  logic fpc_out_valid;
  logic [15:0] fpc_out;
  logic rsp_valid;
  logic rsp_ready;
  logic [15:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_mode;
  modport master (
    output req_valid, req_mode, req_a, req_b, req_tag, fpc_out_valid, fpc_out, rsp_ready,
    input  req_ready, fpc_in_valid, fpc_mode, fpc_in_a, fpc_in_b, rsp_valid, rsp_data, rsp_tag, rsp_mode
  );
  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_tag, fpc_out_valid, fpc_out, rsp_ready,
    output req_ready, fpc_in_valid, fpc_mode, fpc_in_a, fpc_in_b, rsp_valid, rsp_data, rsp_tag, rsp_mode
  );
endinterface

// File: rtl/fpc_op_sched.sv
// fpc_op_sched: buffers tagged bf16 ops and issues them one at a time to Fpc, returning tagged results
module fpc_op_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TIMEOUT = 7
) (
  input  logic clk,
  input  logic rst,
  fpc_op_sched_if.slave bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic err
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 33 + TAG_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] op;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic push, pop, load, tmo;
  assign bus.req_ready = fifo_count != (PW+1)'(DEPTH);
  assign push = bus.req_valid && bus.req_ready;
  assign bus.fpc_in_valid = state == ISSUE;
  assign {bus.fpc_mode, bus.fpc_in_a, bus.fpc_in_b} = bus.fpc_in_valid ? op[EW-1:TAG_W] : '0;
  // next state; issue only when the response slot is guaranteed free on return
  always_comb begin
    pop = state == IDLE && fifo_count != '0 && (!bus.rsp_valid || bus.rsp_ready);
    load = state == WAIT && bus.fpc_out_valid;
    tmo = state == WAIT && !bus.fpc_out_valid && timer == TW'(TIMEOUT - 1);
    nxt = pop ? ISSUE : state == ISSUE ? WAIT : (load || tmo) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // request storage
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {bus.req_mode, bus.req_a, bus.req_b, bus.req_tag};
  // fifo pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // op register and result-wait timer
  always_ff @(posedge clk) begin
    op <= rst ? '0 : pop ? mem[rd_ptr] : op;
    timer <= state == WAIT ? timer + TW'(1) : '0;
  end
  // response slot and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_tag <= '0;
      bus.rsp_mode <= 1'b0;
      err <= 1'b0;
    end else begin
      if (load) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data <= bus.fpc_out;
        bus.rsp_tag <= op[TAG_W-1:0];
        bus.rsp_mode <= op[EW-1];
      end else if (bus.rsp_valid && bus.rsp_ready) bus.rsp_valid <= 1'b0;
      if (tmo || (bus.fpc_out_valid && state != WAIT)) err <= 1'b1;
    end
  end
endmodule

// File: doc/fpc_op_sched.md
Name: fpc_op_sched

Overview:
- Upstream request scheduler for the bfloat16 add/multiply unit (Fpc).
- Accepts tagged operand pairs on a valid/ready interface and buffers them in a request FIFO.
- Issues one operation at a time to Fpc, honouring Fpc's fixed 2-cycle result latency and its busy window.
- Returns each result with its tag on a valid/ready response port; flags protocol errors.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
TAG_W, 4, width of request/response tag
TIMEOUT, 7, max cycles in WAIT before declaring a lost result

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_mode  in  1  0=add, 1=multiply (Fpc encoding)
req_a  in  16  bfloat16 operand A
req_b  in  16  bfloat16 operand B
req_tag  in  TAG_W  caller tag
fpc_in_valid  out  1  to Fpc in_valid
fpc_mode  out  1  to Fpc mode
fpc_in_a  out  16  to Fpc in_a
fpc_in_b  out  16  to Fpc in_b
fpc_out_valid  in  1  from Fpc out_valid
fpc_out  in  16  from Fpc out
rsp_valid  out  1  result held
rsp_ready  in  1  consumer takes result
rsp_data  out  16  bfloat16 result
rsp_tag  out  TAG_W  tag of the result
rsp_mode  out  1  mode of the result
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empties; fifo_count=0; req_ready=1 from the next cycle.
  - state=IDLE; fpc_in_valid=0; fpc_mode/fpc_in_a/fpc_in_b=0.
  - rsp_valid=0; rsp_data/rsp_tag/rsp_mode=0; err=0.
  - Reset mid-operation discards the in-flight op and all queued ops. The system resets Fpc in the same cycle.
- FIFO:
  - req_ready = (fifo_count != DEPTH), registered count, no full bypass.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pop of an empty FIFO cannot occur.
- Issue condition: FIFO non-empty and (!rsp_valid || rsp_ready).
  - This guarantees the response slot is free when the result returns (one op outstanding max).
- FSM:
  - IDLE: if the issue condition holds, pop the head into the op registers (mode, a, b, tag) and go to ISSUE. Otherwise stay.
  - ISSUE: fpc_in_valid=1 for exactly this one cycle; fpc_mode/a/b driven from the op registers; go to WAIT, clear the timer.
  - WAIT: fpc_in_valid=0; timer increments each cycle.
    - On fpc_out_valid: load rsp_data=fpc_out, rsp_tag/rsp_mode from the op registers, set rsp_valid=1 next cycle, go to IDLE.
    - If the timer reaches TIMEOUT: set err, drop the op, go to IDLE.
- fpc_in_a/fpc_in_b/fpc_mode are zero outside ISSUE, matching Fpc's own input zeroing.
- Response:
  - rsp_valid clears on rsp_valid&rsp_ready unless a load occurs in the same cycle. Load has priority, though the issue rule makes that case unreachable.
  - Data and tag stay stable while rsp_valid=1 and rsp_ready=0.
- Errors: err also sets on fpc_out_valid in any state other than WAIT. err clears only on rst.
- Timing, with request accepted in cycle t:
  - pop at t+1, fpc_in_valid at t+2, fpc_out_valid at t+4, rsp_valid at t+5.
- Throughput: one op per 4 cycles with rsp_ready tied high (IDLE, ISSUE, WAIT, WAIT). The next fpc_in_valid is never earlier than 2 cycles after the previous fpc_out_valid, so Fpc is back in its idle state.
- Ordering: responses return strictly in request order.
- Mode and operand values are passed through unmodified; no arithmetic in this block.

Test Plan:
- Single add: req a=0x3F80 (1.0), b=0x4000 (2.0), mode=0, tag=3 at t. Required: fpc_in_valid high only at t+2; rsp_valid at t+5 with rsp_data=0x4040, rsp_tag=3, rsp_mode=0.
- Single multiply: a=0x3FC0 (1.5), b=0x4000, mode=1, tag=9. Required: rsp_data=0x4040, rsp_mode=1, rsp_tag=9. fpc_in_a/b=0 in every non-ISSUE cycle.
- Fill and backpressure: rsp_ready=0, push 6 requests back-to-back with tags 0..5.
  - Required: req_ready drops once fifo_count=4.
  - First result held stable with tag 0, and no further fpc_in_valid.
  - After rsp_ready=1: tags 0..5 returned in order; gaps of 4 cycles between fpc_in_valid pulses.
- Simultaneous push/pop: with fifo_count=2, push in the same cycle the FSM pops. Required: fifo_count stays 2, and no entry is lost or duplicated.
- Timeout: bench Fpc model suppresses out_valid for one op. Required: err=1 exactly TIMEOUT cycles after entering WAIT, FSM back to IDLE, next op completes normally, err stays 1.
- Spurious result and reset: pulse fpc_out_valid while in IDLE → err=1. Then assert rst during WAIT → all outputs 0, fifo_count=0, err=0 next cycle, no rsp_valid for the dropped op.
